// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, default geometry and parity helper for ram_sdp_sync
// Purpose: FSM state encoding, default geometry constants and the byte parity function.
// Ports: none (package).
// Optional feature macro: RAM_PARITY_EN (parity helper is only used when it is defined).
package ram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int BE_W       = DEF_DATA_W / 8;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset clear sweep sequencer for ram_sdp_sync
// Purpose: after reset walks a pointer over every word, requesting a zero write each cycle,
//          then parks in READY until the next reset.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   init_busy           1 while the sweep runs
//   init_we, init_addr  write request and address for the clear write
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_busy = 1'b0;
    init_we   = 1'b0;
    init_addr = ptr;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        init_we   = 1'b1;
        ptr_nxt   = ptr + 1'b1;
        // Last word is written on this edge; READY follows, so the sweep is exactly DEPTH cycles.
        if (&ptr) state_nxt = READY;
      end
      READY: begin
        state_nxt = READY;
      end
    endcase
  end

endmodule

// File: rtl/ram_sdp_sync.sv
// rtl/ram_sdp_sync.sv - synchronous simple-dual-port RAM with byte enables and self-clearing sweep
// Purpose: one write port (byte enables), one read port with RD_LAT (1 or 2) cycle latency and
//          a valid strobe; write-first on same-address collisions; zeroes all words after reset.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   init_busy                           1 while the post-reset clear sweep runs
//   wr_en, wr_addr, wr_data, wr_be      write port; wr_be[i] covers wr_data[8i+7:8i]
//   rd_en, rd_addr                      read request
//   rd_data, rd_valid                   read result, qualified by rd_valid
//   parity_err                          only with RAM_PARITY_EN: per-byte even parity mismatch on read
// Optional feature macro: RAM_PARITY_EN
module ram_sdp_sync
  import ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                init_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
`ifdef RAM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int NUM_WORDS = 2 ** ADDR_W;

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  ram_init_seq #(.ADDR_W(ADDR_W)) u_init (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Storage write port: the sweep owns it while busy, user traffic is dropped.
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [NUM_BYTES-1:0] mem_be;

  always_comb begin
    if (init_busy) begin
      mem_we    = init_we;
      mem_addr  = init_addr;
      mem_wdata = '0;
      mem_be    = '1;
    end else begin
      mem_we    = wr_en;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      mem_be    = wr_be;
    end
  end

  logic [DATA_W-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Write-first bypass: bytes being written to the read address this cycle come from wr_data.
  logic                 rd_fire;
  logic [NUM_BYTES-1:0] byp;
  logic [DATA_W-1:0]    rd_word;

  assign rd_fire = rd_en & ~init_busy;

  always_comb begin
    byp     = '0;
    rd_word = mem[rd_addr];
    for (int i = 0; i < NUM_BYTES; i++) begin
      byp[i] = wr_en & ~init_busy & (wr_addr == rd_addr) & wr_be[i];
      if (byp[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end
    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

`ifdef RAM_PARITY_EN
  logic [NUM_BYTES-1:0] par_mem [NUM_WORDS];
  logic                 rd_bad;
  logic                 s1_perr;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (mem_be[i]) par_mem[mem_addr][i] <= byte_parity(mem_wdata[8*i +: 8]);
      end
    end
  end

  // Bypassed bytes carry freshly computed parity, so they can never mismatch.
  always_comb begin
    rd_bad = 1'b0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (!byp[i] && (par_mem[rd_addr][i] != byte_parity(rd_word[8*i +: 8]))) rd_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_perr <= 1'b0;
    else        s1_perr <= rd_fire & rd_bad;
  end

  if (RD_LAT == 2) begin : g_perr2
    logic s2_perr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s2_perr <= 1'b0;
      else        s2_perr <= s1_perr;
    end
    assign parity_err = s2_perr;
  end else begin : g_perr1
    assign parity_err = s1_perr;
  end
`endif

endmodule
